// File: rtl/async_oneway_transmitter_pkg.sv
// async_oneway_transmitter_pkg: chunk width, FSM states and chunking math shared by the transmitter.
`ifndef MESSAGE_SIZE
`define MESSAGE_SIZE 32
`endif
package async_oneway_transmitter_pkg;
  localparam int CHUNK_W = 6;
  typedef enum logic [2:0] {IDLE, LEAD, SETUP, PULSE, GAP, TAIL} state_t;
  function automatic int nchunk(input int w);
    return (w + CHUNK_W - 1) / CHUNK_W;
  endfunction
  function automatic int pad(input int w);
    return CHUNK_W * nchunk(w) - w;
  endfunction
endpackage

// File: rtl/async_tx_phase_timer.sv
// async_tx_phase_timer: loadable down-counter that parks at zero and flags it.
module async_tx_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign zero = cnt == '0;
endmodule

// File: rtl/async_oneway_transmitter.sv
// async_oneway_transmitter: serialises msg into 6-bit chunks with timed setup/pulse/gap phases.
// Define ASYNC_TX_PENDING_EN to add a one-entry pending message slot.
module async_oneway_transmitter
  import async_oneway_transmitter_pkg::*;
#(
  parameter int MSG_W        = `MESSAGE_SIZE,
  parameter int SETUP_CYCLES = 64,
  parameter int PULSE_CYCLES = 64,
  parameter int GAP_CYCLES   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MSG_W-1:0]   msg,
  output logic               ready,
  output logic               done,
  output logic               transmit_ctrl,
  output logic               packet_pulse,
  output logic [CHUNK_W-1:0] dout
);
  localparam int NCHUNK = nchunk(MSG_W);
  localparam int PAD    = pad(MSG_W);
  localparam int SH_W   = CHUNK_W * NCHUNK;
  localparam int S      = SETUP_CYCLES < 1 ? 1 : SETUP_CYCLES;
  localparam int P      = PULSE_CYCLES < 1 ? 1 : PULSE_CYCLES;
  localparam int G      = GAP_CYCLES < 1 ? 1 : GAP_CYCLES;
  localparam int MX     = S > P ? (S > G ? S : G) : (P > G ? P : G);
  localparam int TW     = $clog2(MX + 1);
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [TW-1:0] S_LD = TW'(S - 1);
  localparam logic [TW-1:0] P_LD = TW'(P - 1);
  localparam logic [TW-1:0] G_LD = TW'(G - 1);
  state_t state, state_n;
  logic [SH_W-1:0] shift, shift_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CHUNK_W-1:0] dout_n;
  logic tc_n, pp_n, done_n, ready_n;
  logic load, zero, accept, go;
  logic [TW-1:0] load_val;
  logic [MSG_W-1:0] src;
`ifdef ASYNC_TX_PENDING_EN
  logic pend, pend_n;
  logic [MSG_W-1:0] pend_msg, pend_msg_n;
  assign go  = accept || pend;
  assign src = pend ? pend_msg : msg;
`else
  assign go  = accept;
  assign src = msg;
`endif
  assign accept = start && ready;
  async_tx_phase_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .zero(zero)
  );
  always_comb begin
    state_n  = state;
    shift_n  = shift;
    cnt_n    = cnt;
    dout_n   = dout;
    tc_n     = transmit_ctrl;
    pp_n     = packet_pulse;
    done_n   = 1'b0;
    load     = 1'b0;
    load_val = S_LD;
`ifdef ASYNC_TX_PENDING_EN
    pend_n     = pend;
    pend_msg_n = pend_msg;
`endif
    case (state)
      IDLE: if (go) begin
        state_n = LEAD;
        shift_n = SH_W'(src) << PAD;
        cnt_n   = CW'(NCHUNK);
        tc_n    = 1'b1;
        load    = 1'b1;
`ifdef ASYNC_TX_PENDING_EN
        pend_n  = 1'b0;
`endif
      end
      LEAD: begin
        tc_n = 1'b1;
        if (zero) begin
          dout_n  = shift[CHUNK_W-1:0];
          state_n = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: if (zero) begin
        pp_n     = 1'b1;
        state_n  = PULSE;
        load     = 1'b1;
        load_val = P_LD;
      end
      PULSE: if (zero) begin
        pp_n     = 1'b0;
        shift_n  = shift >> CHUNK_W;
        cnt_n    = cnt - 1'b1;
        state_n  = GAP;
        load     = 1'b1;
        load_val = G_LD;
      end
      GAP: if (zero) begin
        load     = 1'b1;
        load_val = cnt != '0 ? S_LD : G_LD;
        state_n  = cnt != '0 ? SETUP : TAIL;
        dout_n   = cnt != '0 ? shift[CHUNK_W-1:0] : dout;
      end
      TAIL: if (zero) begin
        tc_n    = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
`ifdef ASYNC_TX_PENDING_EN
        // Relaunch straight into LEAD; transmit_ctrl stays low for this one cycle only.
        if (pend) begin
          state_n = LEAD;
          shift_n = SH_W'(pend_msg) << PAD;
          cnt_n   = CW'(NCHUNK);
          load    = 1'b1;
          pend_n  = 1'b0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
`ifdef ASYNC_TX_PENDING_EN
    if (accept && state != IDLE) begin
      pend_n     = 1'b1;
      pend_msg_n = msg;
    end
    ready_n = !pend_n;
`else
    ready_n = state_n == IDLE && !done_n;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      shift         <= '0;
      cnt           <= '0;
      dout          <= '0;
      transmit_ctrl <= 1'b0;
      packet_pulse  <= 1'b0;
      done          <= 1'b0;
      ready         <= 1'b1;
    end else begin
      state         <= state_n;
      shift         <= shift_n;
      cnt           <= cnt_n;
      dout          <= dout_n;
      transmit_ctrl <= tc_n;
      packet_pulse  <= pp_n;
      done          <= done_n;
      ready         <= ready_n;
    end
`ifdef ASYNC_TX_PENDING_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_msg <= '0;
    end else begin
      pend     <= pend_n;
      pend_msg <= pend_msg_n;
    end
`endif
endmodule

// File: doc/async_oneway_transmitter.md
Name: async_oneway_transmitter

Overview:
- Sending end of the 6-bit one-way chunked link: takes a MESSAGE_SIZE-bit message and serialises it as ceil(MESSAGE_SIZE/6) 6-bit chunks.
- Drives three signals: data bus dout, strobe packet_pulse, and framing signal transmit_ctrl.
- Every phase is held for programmable cycle counts, so a debounced receiver on another board or clock domain samples each chunk cleanly.
- Sits on the master board, fed by the game-state packer, and drives the inter-board pins.

Parameters:
- MSG_W, default MESSAGE_SIZE (from constants.svh): message width in bits.
- SETUP_CYCLES, default 64: cycles dout is stable before packet_pulse rises; also the delay from transmit_ctrl rising to the first chunk.
- PULSE_CYCLES, default 64: cycles packet_pulse is held high.
- GAP_CYCLES, default 64: cycles packet_pulse is held low after each pulse; also the hold time of transmit_ctrl after the last pulse.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: request to send msg; accepted only when ready=1.
- msg, input, MSG_W: message, captured on the accepted start cycle.
- ready, output, 1: high when idle and able to accept start.
- done, output, 1: one-cycle pulse when the transfer completes.
- transmit_ctrl, output, 1: frame signal, high for the whole transfer.
- packet_pulse, output, 1: chunk strobe.
- dout, output, 6: current chunk.

Behaviour:
- Reset values: transmit_ctrl=0, packet_pulse=0, dout=0, done=0, ready=1, state=IDLE, all counters 0, shift register 0. Reset mid-transfer aborts immediately and all outputs drop in the same cycle.
- Constants: NCHUNK = ceil(MSG_W/6); PAD = 6*NCHUNK - MSG_W.
- Captured vector: padded = {msg, PAD'b0}, i.e. zero padding in the LSBs. Chunk k (k = 0 first) = padded[6k+5:6k].
  - Ordering rule: the receiver shifts chunks into the top of its buffer and keeps the upper bits, so the message ends up in its MSBs.
- All outputs are registered. dout only changes while packet_pulse=0 and at least SETUP_CYCLES before the next rising edge.
- State machine:
  - IDLE: ready=1. On start, latch padded into the shift register, set chunk count = NCHUNK, set transmit_ctrl=1, go to LEAD.
  - LEAD: wait SETUP_CYCLES, then drive dout = shift[5:0] and go to SETUP.
  - SETUP: wait SETUP_CYCLES, then set packet_pulse=1 and go to PULSE.
  - PULSE: wait PULSE_CYCLES, then set packet_pulse=0, shift right by 6, decrement the count, and go to GAP.
  - GAP: wait GAP_CYCLES. If count != 0, drive the next dout and go to SETUP; otherwise go to TAIL.
  - TAIL: wait GAP_CYCLES, then set transmit_ctrl=0, pulse done for one cycle, go to IDLE.
- ready is 0 from the cycle after an accepted start until the cycle after done.
- start while ready=0 is ignored (unless the optional feature is enabled).
- A start in the same cycle as done is ignored, because ready is still 0.
- start held high in IDLE starts back-to-back transfers. transmit_ctrl then has at least one low cycle (the IDLE cycle) between frames.
- Phase counter width is $clog2(max(SETUP,PULSE,GAP)+1). A value of 0 for any *_CYCLES parameter is treated as 1.
- MSG_W = 1 gives NCHUNK=1 and PAD=5. MSG_W a multiple of 6 gives PAD=0.
- Total transfer length: SETUP + NCHUNK*(SETUP+PULSE+GAP) + GAP + 1 cycles from the start cycle to the done pulse, inclusive of IDLE exit.

Optional Feature:
- Macro: ASYNC_TX_PENDING_EN.
- Defined:
  - Adds a one-entry pending register. ready stays high while busy as long as the pending slot is empty.
  - A start accepted while busy is stored. On TAIL exit the block goes straight to LEAD with the pending message, with transmit_ctrl forced low for exactly 1 cycle.
  - done pulses once per message.
- Undefined: behaviour exactly as above; no pending storage.

Decomposition:
- Shared package entries: CHUNK_W=6, the state enum typedef (IDLE, LEAD, SETUP, PULSE, GAP, TAIL), and the NCHUNK/PAD computation function. MESSAGE_SIZE remains in constants.svh.
- Sub-module: async_tx_phase_timer, a loadable down-counter with load value input and a zero flag, instantiated once.

Test Plan:
- MSG_W=12, SETUP=PULSE=GAP=4, msg=12'hABC -> chunks 6'h3C then 6'h2A. Two packet_pulse highs of 4 cycles each. done at cycle 4+2*12+4+1=33.
- MSG_W=32, msg=32'hDEADBEEF, PAD=4 -> 6 chunks; the bench receiver model (shift in at top, keep upper 32 bits) recovers 32'hDEADBEEF.
- Check dout never changes while packet_pulse=1, and is stable ≥SETUP cycles before each rising edge. transmit_ctrl is high ≥SETUP cycles before the first pulse and ≥GAP cycles after the last pulse.
- rst_n low during the third PULSE -> all outputs 0 and ready=1 the same cycle. A new start after release transmits the fresh message from chunk 0.
- start held high for 3 transfers -> transmit_ctrl low ≥1 cycle between frames; 3 done pulses. A second start issued mid-transfer is ignored (macro off).
- ASYNC_TX_PENDING_EN defined: start(A), then start(B) mid-transfer -> B sent after A with a 1-cycle transmit_ctrl gap; 2 done pulses. A third start while pending is full is ignored (ready=0).
